feature_transfer_waiter: RTL

//  Multi-channel custom-instruction (CI) delay element for the feature-transfer path.

---
 rtl/ci_wait_pkg.sv | 21 ++
 rtl/channel_event_latch.sv | 63 ++++++
 rtl/feature_transfer_waiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/ci_wait_pkg.sv
// rtl/ci_wait_pkg.sv - shared codes and constants for the feature-transfer CI waiter
// Purpose: mode encodings, fixed result words and FSM state encoding used by
//          feature_transfer_waiter and its testbench.
package ci_wait_pkg;

    localparam logic [1:0] MODE_WAIT    = 2'd0;
    localparam logic [1:0] MODE_POLL    = 2'd1;
    localparam logic [1:0] MODE_TIMEOUT = 2'd2;
    localparam logic [1:0] MODE_CLEAR   = 2'd3;

    localparam logic [31:0] RESULT_NO_DATA     = 32'h8000_0000;
    localparam logic [31:0] RESULT_BAD_CHANNEL = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/channel_event_latch.sv
// rtl/channel_event_latch.sv - per-channel transfer-complete edge latch with count capture
// Purpose: detects a rising edge of data_ready_i, sets pending and captures count_i.
//          clear_i drops pending unless a new edge arrives the same cycle (set wins).
// Ports:
//   clock, reset   system clock, synchronous active-high reset
//   data_ready_i   transfer-complete level from the engine
//   count_i        feature count sampled on the rising edge
//   clear_i        consume request from the CI FSM
//   pending_o      event latched and not yet consumed
//   count_o        count captured with the most recent edge
module channel_event_latch #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   data_ready_i,
    input  logic [COUNT_WIDTH-1:0] count_i,
    input  logic                   clear_i,
    output logic                   pending_o,
    output logic [COUNT_WIDTH-1:0] count_o
);

    logic                   armed_q;
    logic                   prev_q;
    logic                   pending_q;
    logic                   pending_d;
    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] count_d;
    logic                   rise;

    // armed_q stays low for the first cycle after reset so that prev_q can
    // absorb a level that was already high; such a level is not a new event.
    assign rise = armed_q & data_ready_i & ~prev_q;

    always_comb begin
        pending_d = pending_q;
        count_d   = count_q;
        if (rise) begin
            pending_d = 1'b1;
            count_d   = count_i;
        end else if (clear_i) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            armed_q   <= 1'b0;
            prev_q    <= 1'b0;
            pending_q <= 1'b0;
            count_q   <= '0;
        end else begin
            armed_q   <= 1'b1;
            prev_q    <= data_ready_i;
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

    assign pending_o = pending_q;
    assign count_o   = count_q;

endmodule

// File: rtl/feature_transfer_waiter.sv
// rtl/feature_transfer_waiter.sv - multi-channel CI wait/poll/timeout/clear on transfer events
// Purpose: lets the CPU block on, poll, time out on or clear per-channel transfer-complete events.
// Ports:
//   clock, reset      system clock, synchronous active-high reset
//   dataReady         per-channel transfer-complete levels
//   numberOfFeatures  packed per-channel counts, channel i at [i*COUNT_WIDTH +: COUNT_WIDTH]
//   ciStart/ciCke/ciN CI handshake; accepted only in IDLE
//   ciValueA          [1:0] mode, [11:8] channel select
//   ciValueB          timeout in cycles (TIMEOUT mode)
//   ciDone/ciResult   registered one-cycle completion and result (result 0 otherwise)
//   pendingMask       per-channel pending flags
module feature_transfer_waiter
    import ci_wait_pkg::*;
#(
    parameter logic [7:0] CUSTOM_INSTRUCTION_ID = 8'd0,
    parameter int         NUM_CHANNELS          = 4,
    parameter int         COUNT_WIDTH           = 16
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [NUM_CHANNELS-1:0]             dataReady,
    input  logic [NUM_CHANNELS*COUNT_WIDTH-1:0] numberOfFeatures,
    input  logic                                ciStart,
    input  logic                                ciCke,
    input  logic [7:0]                          ciN,
    input  logic [31:0]                         ciValueA,
    input  logic [31:0]                         ciValueB,
    output logic                                ciDone,
    output logic [31:0]                         ciResult,
    output logic [NUM_CHANNELS-1:0]             pendingMask
);

    state_t      state_q;
    logic [1:0]  mode_q;
    logic [3:0]  sel_q;
    logic [31:0] timer_q;
    logic        done_q;
    logic [31:0] result_q;

    logic [NUM_CHANNELS-1:0]             pending;
    logic [NUM_CHANNELS-1:0]             chan_clear;
    logic [NUM_CHANNELS*COUNT_WIDTH-1:0] counts;

    // Channel data padded to the full 16-entry select space so the 4-bit
    // select indexes without range issues; unused entries read as empty.
    logic [15:0]            pend_ext;
    logic [COUNT_WIDTH-1:0] cnt_ext [16];

    logic                   accept;
    logic                   sel_valid;
    logic                   sel_pending;
    logic [COUNT_WIDTH-1:0] sel_count;
    logic                   take_success;
    logic                   clear_all;
    logic                   unused_bits;

    assign unused_bits = ^{ciValueA[31:12], ciValueA[7:2]};

    generate
        for (genvar g = 0; g < 16; g++) begin : g_ch
            if (g < NUM_CHANNELS) begin : g_live
                channel_event_latch #(
                    .COUNT_WIDTH(COUNT_WIDTH)
                ) u_latch (
                    .clock       (clock),
                    .reset       (reset),
                    .data_ready_i(dataReady[g]),
                    .count_i     (numberOfFeatures[g*COUNT_WIDTH +: COUNT_WIDTH]),
                    .clear_i     (chan_clear[g]),
                    .pending_o   (pending[g]),
                    .count_o     (counts[g*COUNT_WIDTH +: COUNT_WIDTH])
                );
                assign cnt_ext[g] = counts[g*COUNT_WIDTH +: COUNT_WIDTH];
            end else begin : g_pad
                assign cnt_ext[g] = '0;
            end
        end
    endgenerate

    assign pend_ext    = 16'(pending);
    assign accept      = ciStart && ciCke && (ciN == CUSTOM_INSTRUCTION_ID);
    assign sel_valid   = (32'(sel_q) < 32'(NUM_CHANNELS));
    assign sel_pending = pend_ext[sel_q];
    assign sel_count   = cnt_ext[sel_q];

    // A successful completion consumes the selected event on the same edge
    // that moves the FSM into DONE; CLEAR never consumes through this path.
    assign take_success = sel_valid && sel_pending &&
                          (((state_q == ST_EVAL) && (mode_q != MODE_CLEAR)) ||
                           (state_q == ST_WAIT));
    assign clear_all    = (state_q == ST_EVAL) && sel_valid && (mode_q == MODE_CLEAR);

    always_comb begin
        chan_clear = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            chan_clear[i] = clear_all || (take_success && (sel_q == 4'(i)));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_WAIT;
            sel_q    <= '0;
            timer_q  <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q   <= 1'b0;
                    result_q <= '0;
                    if (accept) begin
                        mode_q  <= ciValueA[1:0];
                        sel_q   <= ciValueA[11:8];
                        timer_q <= ciValueB;
                        state_q <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    if (!sel_valid) begin
                        state_q  <= ST_DONE;
                        done_q   <= 1'b1;
                        result_q <= RESULT_BAD_CHANNEL;
                    end else if (mode_q == MODE_CLEAR) begin
                        state_q  <= ST_DONE;
                        done_q   <= 1'b1;
                        result_q <= 32'(pending);
                    end else if (take_success) begin
                        state_q  <= ST_DONE;
                        done_q   <= 1'b1;
                        result_q <= 32'(sel_count);
                    end else if ((mode_q == MODE_POLL) ||
                                 ((mode_q == MODE_TIMEOUT) && (timer_q == 32'd0))) begin
                        state_q  <= ST_DONE;
                        done_q   <= 1'b1;
                        result_q <= RESULT_NO_DATA;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (take_success) begin
                        state_q  <= ST_DONE;
                        done_q   <= 1'b1;
                        result_q <= 32'(sel_count);
                    end else if ((mode_q == MODE_TIMEOUT) && (timer_q == 32'd1)) begin
                        state_q  <= ST_DONE;
                        done_q   <= 1'b1;
                        result_q <= RESULT_NO_DATA;
                    end else if (timer_q > 32'd1) begin
                        timer_q <= timer_q - 32'd1;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    done_q   <= 1'b0;
                    result_q <= '0;
                end
            endcase
        end
    end

    assign ciDone      = done_q;
    assign ciResult    = result_q;
    assign pendingMask = pending;

endmodule
